// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM states, command bundle, defaults.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    localparam int APB_ADDR_W          = 32;
    localparam int APB_DATA_W          = 32;
    localparam int APB_DEFAULT_TIMEOUT = 16;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait-state counter; flags expiry on the LIMIT-th stalled cycle.
module apb_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_pready,
    output logic o_expired
);

    logic [7:0] r_cnt;

    // Held at zero outside ACCESS, so every ACCESS entry starts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (!i_run) begin
            r_cnt <= 8'd0;
        end else if (!i_pready) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_expired = i_run && !i_pready && (r_cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding valid/ready to APB requester.
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = APB_DEFAULT_TIMEOUT
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES out of range 1..255");
    end

    apb_mst_state_e    r_state;
    apb_mst_state_e    w_next;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              w_accept;
    logic              w_done;
    logic              w_expired;

`ifdef APB_TIMEOUT_EN
    apb_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk      (pclk),
        .rst_n    (preset_n),
        .i_run    (r_state == ACCESS),
        .i_pready (pready),
        .o_expired(w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_done   = (r_state == ACCESS) && pready;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (req_valid) w_next = SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (pready || w_expired) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        unique case (r_state)
            IDLE:    req_ready = 1'b1;
            SETUP:   psel = 1'b1;
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            RESP:    rsp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    // Command fields change only on acceptance and hold through RESP/IDLE.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
        end else if (w_accept) begin
            r_paddr  <= req_addr;
            r_pwrite <= req_write;
            r_pwdata <= req_wdata;
        end
    end

    // pready beats a same-cycle expiry, so completion is checked first.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_done) begin
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
            r_rsp_err   <= 1'b0;
        end else if (w_expired) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
        end else if (r_state == IDLE) begin
            r_rsp_err   <= 1'b0;
        end
    end

    assign paddr     = r_paddr;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge with a wait-state APB slave model.
// Timeout cases run only when APB_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

`ifdef APB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 16;
`endif

    logic        pclk;
    logic        preset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    apb_master_bridge #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk(pclk), .preset_n(preset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Slave model: pready after `waits` stalled ACCESS cycles unless stuck.
    logic [31:0] mem [16];
    int waits = 0;
    int acnt  = 0;
    bit stuck = 1'b0;

    initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    always @(posedge pclk or negedge preset_n) begin
        if (!preset_n) acnt <= 0;
        else if (psel && penable && !pready) acnt <= acnt + 1;
        else acnt <= 0;
    end

    assign pready = psel && penable && !stuck && (acnt >= waits);
    assign prdata = mem[paddr[5:2]];

    always @(posedge pclk) begin
        if (preset_n && psel && penable && pready && pwrite)
            mem[paddr[5:2]] <= pwdata;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          rcyc;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int acc_cnt = 0;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_wr;

    always @(negedge pclk) begin
        if (!preset_n) begin
            acc_cnt = 0;
        end else begin
            if (psel && !penable) begin
                s_addr  = paddr;
                s_wdata = pwdata;
                s_wr    = pwrite;
            end
            if (psel && penable) begin
                acc_cnt++;
                chk("paddr_stable", paddr, s_addr);
                chk("pwdata_stable", pwdata, s_wdata);
                chk("pwrite_stable", 32'(pwrite), 32'(s_wr));
            end
            if (psel || rsp_valid)
                chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                    chk("rsp_cycle", 32'(cyc), 32'(mon_e.rcyc));
                    chk("access_cycles", 32'(acc_cnt), 32'(mon_e.acc));
                end
                acc_cnt = 0;
            end
        end
    end

    // acc = number of ACCESS cycles expected; response follows the last one.
    task automatic send(input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er,
                        input bit ee, input int acc, input bit hold,
                        output int acyc);
        exp_t e;
        @(negedge pclk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        acyc = -1;
        for (int k = 0; k < 50; k++) begin
            if (req_ready) begin
                acyc = cyc + 1;
                break;
            end
            @(negedge pclk);
        end
        if (acyc < 0) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
        end else begin
            e.rdata = er;
            e.err   = ee;
            e.rcyc  = acyc + 1 + acc;
            e.acc   = acc;
            sbq.push_back(e);
            @(posedge pclk);
            if (!hold) begin
                #1;
                req_valid = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge pclk);
            if (sbq.size() == 0 && req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    int a1, a2, a3;
    bit seen;

    initial begin
        preset_n  = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (2) @(negedge pclk);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        preset_n = 1'b1;

        // Zero-wait write with phase timing checks.
        send(1'b1, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1'b0, a1);
        @(negedge pclk);
        chk("setup_psel", 32'(psel), 32'd1);
        chk("setup_penable", 32'(penable), 32'd0);
        chk("setup_pwdata", pwdata, 32'hDEADBEEF);
        chk("setup_pwrite", 32'(pwrite), 32'd1);
        @(negedge pclk);
        chk("access_psel", 32'(psel), 32'd1);
        chk("access_penable", 32'(penable), 32'd1);
        chk("access_pwdata", pwdata, 32'hDEADBEEF);
        wait_idle();

        send(1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1, 1'b0, a1);
        send(1'b0, 32'h4, 32'h0, 32'h0, 1'b0, 1, 1'b0, a1);
        wait_idle();
        chk("rdata_hold", rsp_rdata, 32'h0);

        // Three wait states: four ACCESS cycles each.
        waits = 3;
        send(1'b1, 32'h8, 32'h12345678, 32'h0, 1'b0, 4, 1'b0, a1);
        send(1'b0, 32'h8, 32'h0, 32'h12345678, 1'b0, 4, 1'b0, a1);
        wait_idle();
        waits = 0;

        // Back-to-back with req_valid held high.
        send(1'b1, 32'hC, 32'hA5A5A5A5, 32'h0, 1'b0, 1, 1'b1, a1);
        send(1'b0, 32'hC, 32'h0, 32'hA5A5A5A5, 1'b0, 1, 1'b1, a2);
        send(1'b0, 32'h8, 32'h0, 32'h12345678, 1'b0, 1, 1'b0, a3);
        chk("bp_gap1", 32'(a2 - a1), 32'd4);
        chk("bp_gap2", 32'(a3 - a2), 32'd4);
        wait_idle();

        // Reset while in ACCESS.
        waits = 6;
        send(1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 7, 1'b0, a1);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge pclk);
            if (penable) begin
                seen = 1'b1;
                break;
            end
        end
        chk("saw_access", 32'(seen), 32'd1);
        #2;
        preset_n = 1'b0;
        #1;
        chk("arst_psel", 32'(psel), 32'd0);
        chk("arst_penable", 32'(penable), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        sbq.delete();
        repeat (2) @(negedge pclk);
        preset_n = 1'b1;
        waits = 0;
        repeat (12) @(negedge pclk);
        send(1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1, 1'b0, a1);
        wait_idle();

`ifdef APB_TIMEOUT_EN
        stuck = 1'b1;
        send(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, TMO, 1'b0, a1);
        wait_idle();
        stuck = 1'b0;
        @(negedge pclk);
        chk("err_cleared", 32'(rsp_err), 32'd0);
        waits = 3;
        send(1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 4, 1'b0, a1);
        wait_idle();
        waits = 0;
`endif

        repeat (3) @(negedge pclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Single-outstanding APB requester that sits directly upstream of the APB add-slave. It converts a simple valid/ready command port from the local controller into compliant APB SETUP/ACCESS phases, and returns read data or completion status on a one-cycle response strobe. One clock domain (pclk); asynchronous active-low reset (preset_n).

Parameters:
ADDR_W, 32, width of paddr and req_addr
DATA_W, 32, width of pwdata/prdata/req_wdata/rsp_rdata
TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles waiting for pready (used only with APB_TIMEOUT_EN); legal range 1..255

Ports:
pclk  input  1  APB clock; all logic rising-edge
preset_n  input  1  asynchronous active-low reset
req_valid  input  1  command present
req_ready  output  1  bridge can accept a command (high only in IDLE)
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  target address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle completion strobe
rsp_rdata  output  DATA_W  read data; 0 for writes
rsp_err  output  1  1 = transfer timed out (constant 0 without APB_TIMEOUT_EN)
psel  output  1  APB select
penable  output  1  APB enable
paddr  output  ADDR_W  APB address
pwrite  output  1  APB direction
pwdata  output  DATA_W  APB write data
prdata  input  DATA_W  APB read data
pready  input  1  APB ready from slave

Behaviour:
- Reset (async, preset_n low):
  - State goes to IDLE.
  - psel, penable, paddr, pwrite, pwdata, rsp_valid, rsp_rdata and rsp_err are all 0.
  - Any in-flight transfer is dropped; no response is issued after reset.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, capture req_write/req_addr/req_wdata into paddr/pwrite/pwdata, then go to SETUP.
- SETUP: psel = 1, penable = 0. Unconditionally go to ACCESS next cycle.
- ACCESS:
  - psel = 1, penable = 1.
  - When pready = 1: register prdata into rsp_rdata if reading (0 if writing), then go to RESP.
  - When pready = 0: stay in ACCESS (wait states are unbounded without the macro).
- RESP:
  - psel = penable = 0; rsp_valid = 1 for exactly one cycle; then go to IDLE.
  - The response cannot be back-pressured.
- paddr/pwrite/pwdata:
  - Stable from SETUP through the end of ACCESS.
  - Hold their last value in RESP and IDLE; they change only on acceptance.
- Latency: accept at edge N; SETUP in cycle N+1; ACCESS in N+2 (zero-wait slave completes there); rsp_valid in N+3.
- Throughput: at most one transfer per 4 cycles; req_ready is low in SETUP, ACCESS and RESP.
- req_valid held high while busy is ignored until the bridge returns to IDLE. The command must be held by the source until it is accepted.
- pready sampled outside ACCESS is ignored.
- rsp_rdata holds its value until the next response.

Optional Feature:
APB_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with pready = 0.
  - If the count reaches TIMEOUT_CYCLES, go to RESP with rsp_err = 1 and rsp_rdata = 0; psel/penable drop that cycle.
  - pready arriving in the same cycle as expiry wins: normal completion, rsp_err = 0.
  - rsp_err is valid only with rsp_valid and is cleared in IDLE.
- Not defined: no counter; ACCESS waits indefinitely; rsp_err is tied to 0.

Decomposition:
- apb_pkg gets:
  - typedef enum apb_mst_state_e {IDLE, SETUP, ACCESS, RESP};
  - struct apb_req_t {write, addr, wdata};
  - localparam APB_DEFAULT_TIMEOUT = 16.
- Optional sub-module apb_timeout_ctr: counter plus expiry compare, instantiated only under APB_TIMEOUT_EN.
- The FSM and datapath stay in apb_master_bridge.

Test Plan:
- Write, zero-wait slave: req write addr 0x0 data 0xDEADBEEF → psel rises at N+1, penable at N+2, pwdata = 0xDEADBEEF stable both cycles, rsp_valid at N+3 with rsp_rdata = 0, rsp_err = 0.
- Readback: read addr 0x0 after the previous write → rsp_rdata = 0xDEADBEEF; a read of addr 0x4 → rsp_rdata = 0.
- Wait states: slave holds pready low for 3 ACCESS cycles → psel/penable/paddr stable for 4 ACCESS cycles; rsp_valid 1 cycle after pready.
- Busy back-pressure: req_valid held high continuously → acceptances exactly every 4 cycles; req_ready low in SETUP/ACCESS/RESP.
- Reset mid-ACCESS: deassert preset_n while penable = 1 → psel/penable/rsp_valid go 0 immediately (asynchronously); no rsp_valid after reset release; next request completes normally.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES = 4): pready stuck at 0 → rsp_valid with rsp_err = 1 and rsp_rdata = 0 after 4 ACCESS cycles. A repeat run with pready on the 4th cycle → rsp_err = 0.
